// File: rtl/vga_sync_out.sv
// VGA timing generator plus registered output stage: pixel-rate divider, scan counters,
// and blanked colour / sync registers that lag the counters by exactly one pixel.
module vga_sync_out #(
    parameter int DIV = 4,
    parameter int HD  = 640,
    parameter int HF  = 16,
    parameter int HR  = 96,
    parameter int HB  = 48,
    parameter int VD  = 480,
    parameter int VF  = 10,
    parameter int VR  = 2,
    parameter int VB  = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] graph_rgb,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        video_on,
    output logic        p_tick,
    output logic        f_tick,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb
);
    localparam int H_TOT = HD + HF + HR + HB;
    localparam int V_TOT = VD + VF + VR + VB;
    localparam int DW    = $clog2(DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [9:0]    H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0]    H_DISP   = 10'(HD);
    localparam logic [9:0]    V_DISP   = 10'(VD);
    localparam logic [9:0]    HS_BEG   = 10'(HD + HF);
    localparam logic [9:0]    HS_END   = 10'(HD + HF + HR - 1);
    localparam logic [9:0]    VS_BEG   = 10'(VD + VF);
    localparam logic [9:0]    VS_END   = 10'(VD + VF + VR - 1);

    logic [DW-1:0] r_div_cnt;
    logic [9:0]    r_h_cnt;
    logic [9:0]    r_v_cnt;
    logic          r_hsync;
    logic          r_vsync;
    logic [11:0]   r_rgb;

    logic w_p_tick;
    logic w_h_end;
    logic w_v_end;
    logic w_video_on;
    logic w_hs_act;
    logic w_vs_act;

    assign w_p_tick   = (r_div_cnt == DIV_LAST);
    assign w_h_end    = (r_h_cnt == H_LAST);
    assign w_v_end    = (r_v_cnt == V_LAST);
    assign w_video_on = (r_h_cnt < H_DISP) && (r_v_cnt < V_DISP);
    assign w_hs_act   = (r_h_cnt >= HS_BEG) && (r_h_cnt <= HS_END);
    assign w_vs_act   = (r_v_cnt >= VS_BEG) && (r_v_cnt <= VS_END);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div_cnt <= '0;
        end else if (w_p_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
        end
    end

    // Vertical count advances only on the tick that wraps the line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_p_tick) begin
            r_h_cnt <= w_h_end ? 10'd0 : r_h_cnt + 10'd1;
            if (w_h_end) begin
                r_v_cnt <= w_v_end ? 10'd0 : r_v_cnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= 12'h000;
        end else if (w_p_tick) begin
            r_hsync <= ~w_hs_act;
            r_vsync <= ~w_vs_act;
            r_rgb   <= w_video_on ? graph_rgb : 12'h000;
        end
    end

    assign pix_x    = r_h_cnt;
    assign pix_y    = r_v_cnt;
    assign video_on = w_video_on;
    assign p_tick   = w_p_tick;
    assign f_tick   = w_p_tick && w_h_end && w_v_end;
    assign hsync    = r_hsync;
    assign vsync    = r_vsync;
    assign rgb      = r_rgb;
endmodule

// File: tb/tb_vga_sync_out.sv
// Directed bench: full-size instance for line/hsync/reset behaviour, shrunk instance
// for whole-frame, vsync and f_tick behaviour.
module tb_vga_sync_out;
    logic clk = 1'b0;
    logic rst_d = 1'b1;
    logic rst_s = 1'b1;
    logic [11:0] rgb_in_d = 12'h000;
    logic [11:0] rgb_in_s = 12'h000;

    logic [9:0]  d_pix_x, d_pix_y, s_pix_x, s_pix_y;
    logic        d_video_on, d_p_tick, d_f_tick, d_hsync, d_vsync;
    logic        s_video_on, s_p_tick, s_f_tick, s_hsync, s_vsync;
    logic [11:0] d_rgb, s_rgb;

    int n_chk = 0;
    int n_pass = 0;
    int tmo = 0;
    int stray_f = 0;

    always #5 clk = ~clk;

    vga_sync_out u_dut_d (
        .clk(clk), .reset(rst_d), .graph_rgb(rgb_in_d),
        .pix_x(d_pix_x), .pix_y(d_pix_y), .video_on(d_video_on),
        .p_tick(d_p_tick), .f_tick(d_f_tick), .hsync(d_hsync),
        .vsync(d_vsync), .rgb(d_rgb)
    );

    vga_sync_out #(
        .DIV(2), .HD(8), .HF(2), .HR(2), .HB(2),
        .VD(4), .VF(1), .VR(1), .VB(1)
    ) u_dut_s (
        .clk(clk), .reset(rst_s), .graph_rgb(rgb_in_s),
        .pix_x(s_pix_x), .pix_y(s_pix_y), .video_on(s_video_on),
        .p_tick(s_p_tick), .f_tick(s_f_tick), .hsync(s_hsync),
        .vsync(s_vsync), .rgb(s_rgb)
    );

    // Advance to the next negedge where p_tick is high; w = clocks waited.
    task automatic tick_d(output int w);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!d_p_tick && w < 64);
        if (!d_p_tick) tmo++;
    endtask

    task automatic tick_s(output int w);
        w = 0;
        do begin
            @(negedge clk);
            w++;
            if (!s_p_tick && s_f_tick) stray_f++;
        end while (!s_p_tick && w < 64);
        if (!s_p_tick) tmo++;
    endtask

    task automatic test_reset;
        rgb_in_d = 12'hF0F;
        rgb_in_s = 12'h5A3;
        #2;
        rst_d = 1'b0;
        rst_s = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({d_pix_x, d_pix_y} !== 20'd0) $display("FAIL reset_xy got %0d,%0d want 0,0", d_pix_x, d_pix_y);
        else n_pass++;
        n_chk++;
        if ({d_hsync, d_vsync} !== 2'b11) $display("FAIL reset_sync got %b%b want 11", d_hsync, d_vsync);
        else n_pass++;
        n_chk++;
        if (d_rgb !== 12'h000) $display("FAIL reset_rgb got %h want 000", d_rgb);
        else n_pass++;
        n_chk++;
        if ({d_p_tick, d_f_tick} !== 2'b00) $display("FAIL reset_ticks got %b%b want 00", d_p_tick, d_f_tick);
        else n_pass++;
        n_chk++;
        if (d_video_on !== 1'b1) $display("FAIL reset_video_on got %b want 1", d_video_on);
        else n_pass++;
        n_chk++;
        if ({s_pix_x, s_pix_y, s_hsync, s_vsync, s_rgb, s_p_tick} !== {20'd0, 2'b11, 12'h000, 1'b0})
            $display("FAIL reset_small got x=%0d y=%0d hs=%b vs=%b rgb=%h pt=%b want 0 0 1 1 000 0",
                     s_pix_x, s_pix_y, s_hsync, s_vsync, s_rgb, s_p_tick);
        else n_pass++;
    endtask

    task automatic test_first_tick;
        logic [3:0] pt;
        rst_d = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pt[i] = d_p_tick;
        end
        n_chk++;
        if (pt !== 4'b0100) $display("FAIL first_tick p_tick seq got %b want 0100 (lsb first clk)", pt);
        else n_pass++;
        n_chk++;
        if (d_pix_x !== 10'd1) $display("FAIL first_tick_x got %0d want 1", d_pix_x);
        else n_pass++;
    endtask

    task automatic test_line;
        int w, ex_h, ex_v, e_err_xy, e_err_hs, e_err_rgb, e_err_sp, n_low, first_low, n_blank;
        logic e_hs, saw_step;
        logic [11:0] e_rgb;
        ex_h = 1; ex_v = 0; e_hs = 1'b1; e_rgb = 12'hF0F;
        e_err_xy = 0; e_err_hs = 0; e_err_rgb = 0; e_err_sp = 0;
        n_low = 0; first_low = -1; n_blank = 0; saw_step = 1'b0;
        for (int k = 0; k < 802; k++) begin
            tick_d(w);
            if (k > 0 && w != 4) e_err_sp++;
            if (d_pix_x !== 10'(ex_h) || d_pix_y !== 10'(ex_v)) e_err_xy++;
            if (d_hsync !== e_hs) e_err_hs++;
            if (d_rgb !== e_rgb) e_err_rgb++;
            if (d_rgb === 12'h000) n_blank++;
            if (d_hsync === 1'b0) begin
                n_low++;
                if (first_low < 0) first_low = int'(d_pix_x);
            end
            if (ex_h == 0 && d_pix_x === 10'd0 && d_pix_y === 10'd1) saw_step = 1'b1;
            e_hs  = !(ex_h >= 656 && ex_h <= 751);
            e_rgb = (ex_h < 640 && ex_v < 480) ? 12'hF0F : 12'h000;
            ex_h++;
            if (ex_h == 800) begin ex_h = 0; ex_v++; end
        end
        n_chk++;
        if (e_err_sp != 0) $display("FAIL line_tick_spacing got %0d bad gaps want 0", e_err_sp);
        else n_pass++;
        n_chk++;
        if (e_err_xy != 0) $display("FAIL line_xy got %0d bad ticks want 0", e_err_xy);
        else n_pass++;
        n_chk++;
        if (!saw_step) $display("FAIL line_wrap_y got no 0,1 after wrap want pix_y=1 at pix_x=0");
        else n_pass++;
        n_chk++;
        if (e_err_hs != 0) $display("FAIL line_hsync got %0d bad ticks want 0", e_err_hs);
        else n_pass++;
        n_chk++;
        if (n_low != 96) $display("FAIL hsync_width got %0d want 96", n_low);
        else n_pass++;
        n_chk++;
        if (first_low != 657) $display("FAIL hsync_start got pix_x %0d want 657", first_low);
        else n_pass++;
        n_chk++;
        if (e_err_rgb != 0) $display("FAIL line_rgb got %0d bad ticks want 0", e_err_rgb);
        else n_pass++;
        n_chk++;
        if (n_blank != 160) $display("FAIL line_blank_count got %0d want 160", n_blank);
        else n_pass++;
    endtask

    task automatic test_mid_reset;
        int w;
        logic [3:0] pt;
        for (int k = 0; k < 400 && d_pix_x !== 10'd300; k++) tick_d(w);
        n_chk++;
        if (d_pix_x !== 10'd300 || d_pix_y !== 10'd1 || d_rgb !== 12'hF0F)
            $display("FAIL midreset_pre got x=%0d y=%0d rgb=%h want 300 1 f0f", d_pix_x, d_pix_y, d_rgb);
        else n_pass++;
        #1 rst_d = 1'b0;
        #1;
        n_chk++;
        if ({d_pix_x, d_pix_y} !== 20'd0) $display("FAIL midreset_xy got %0d,%0d want 0,0", d_pix_x, d_pix_y);
        else n_pass++;
        n_chk++;
        if ({d_hsync, d_vsync, d_rgb, d_p_tick, d_f_tick} !== {2'b11, 12'h000, 2'b00})
            $display("FAIL midreset_out got hs=%b vs=%b rgb=%h pt=%b ft=%b want 1 1 000 0 0",
                     d_hsync, d_vsync, d_rgb, d_p_tick, d_f_tick);
        else n_pass++;
        @(negedge clk);
        rst_d = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pt[i] = d_p_tick;
        end
        n_chk++;
        if (pt !== 4'b0100 || d_pix_x !== 10'd1)
            $display("FAIL midreset_restart got seq=%b x=%0d want 0100 1", pt, d_pix_x);
        else n_pass++;
    endtask

    task automatic test_small_frame;
        int w, ex_h, ex_v, e_xy, e_vo, e_ft, e_hs, e_vs, e_rgb_n, e_sp, n_f, n_hl, n_vl;
        logic x_hs, x_vs;
        logic [11:0] x_rgb;
        ex_h = 0; ex_v = 0; x_hs = 1'b1; x_vs = 1'b1; x_rgb = 12'h000;
        e_xy = 0; e_vo = 0; e_ft = 0; e_hs = 0; e_vs = 0; e_rgb_n = 0; e_sp = 0;
        n_f = 0; n_hl = 0; n_vl = 0;
        rst_s = 1'b1;
        for (int k = 0; k < 196; k++) begin
            tick_s(w);
            if (k > 0 && w != 2) e_sp++;
            if (s_pix_x !== 10'(ex_h) || s_pix_y !== 10'(ex_v)) e_xy++;
            if (s_video_on !== (ex_h < 8 && ex_v < 4)) e_vo++;
            if (s_f_tick !== (ex_h == 13 && ex_v == 6)) e_ft++;
            if (s_hsync !== x_hs) e_hs++;
            if (s_vsync !== x_vs) e_vs++;
            if (s_rgb !== x_rgb) e_rgb_n++;
            if (s_f_tick === 1'b1) n_f++;
            if (s_hsync === 1'b0) n_hl++;
            if (s_vsync === 1'b0) n_vl++;
            x_hs  = !(ex_h >= 10 && ex_h <= 11);
            x_vs  = !(ex_v == 5);
            x_rgb = (ex_h < 8 && ex_v < 4) ? 12'h5A3 : 12'h000;
            ex_h++;
            if (ex_h == 14) begin
                ex_h = 0;
                ex_v = (ex_v == 6) ? 0 : ex_v + 1;
            end
        end
        tick_s(w);
        n_chk++;
        if (e_sp != 0 || e_xy != 0) $display("FAIL small_xy got %0d gap errs %0d coord errs want 0 0", e_sp, e_xy);
        else n_pass++;
        n_chk++;
        if (e_vo != 0) $display("FAIL small_video_on got %0d bad ticks want 0", e_vo);
        else n_pass++;
        n_chk++;
        if (e_ft != 0 || n_f != 2) $display("FAIL small_f_tick got %0d misplaced, %0d pulses want 0, 2", e_ft, n_f);
        else n_pass++;
        n_chk++;
        if (stray_f != 0) $display("FAIL small_f_tick_stray got %0d want 0", stray_f);
        else n_pass++;
        n_chk++;
        if (e_hs != 0 || n_hl != 28) $display("FAIL small_hsync got %0d errs, %0d low want 0, 28", e_hs, n_hl);
        else n_pass++;
        n_chk++;
        if (e_vs != 0 || n_vl != 28) $display("FAIL small_vsync got %0d errs, %0d low want 0, 28", e_vs, n_vl);
        else n_pass++;
        n_chk++;
        if (e_rgb_n != 0) $display("FAIL small_rgb got %0d bad ticks want 0", e_rgb_n);
        else n_pass++;
        n_chk++;
        if ({s_pix_x, s_pix_y} !== 20'd0) $display("FAIL small_wrap got %0d,%0d want 0,0", s_pix_x, s_pix_y);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_line();
        test_mid_reset();
        test_small_frame();
        n_chk++;
        if (tmo != 0) $display("FAIL tick_timeout got %0d timeouts want 0", tmo);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
